// File: rtl/lru_way_tracker_if.sv
// Request/response bundle between the buffer manager and lru_way_tracker.
// lock_mask exists only when LRU_LOCK_EN is defined.
interface lru_way_tracker_if #(
    parameter int WAYS = 4
);
    localparam int WAY_W = $clog2(WAYS);

    logic             ref_vld;
    logic [WAY_W-1:0] ref_way;
    logic             inv_vld;
    logic [WAY_W-1:0] inv_way;
    logic             alloc_req;
    logic             alloc_vld;
    logic [WAY_W-1:0] alloc_way;
    logic             alloc_fail;
    logic             all_valid;
`ifdef LRU_LOCK_EN
    logic [WAYS-1:0]  lock_mask;

    modport master (
        output ref_vld, ref_way, inv_vld, inv_way, alloc_req, lock_mask,
        input  alloc_vld, alloc_way, alloc_fail, all_valid
    );

    modport slave (
        input  ref_vld, ref_way, inv_vld, inv_way, alloc_req, lock_mask,
        output alloc_vld, alloc_way, alloc_fail, all_valid
    );
`else
    modport master (
        output ref_vld, ref_way, inv_vld, inv_way, alloc_req,
        input  alloc_vld, alloc_way, alloc_fail, all_valid
    );

    modport slave (
        input  ref_vld, ref_way, inv_vld, inv_way, alloc_req,
        output alloc_vld, alloc_way, alloc_fail, all_valid
    );
`endif
endinterface

// File: rtl/lru_way_tracker.sv
// N-way true-LRU tracker for one set: pairwise age matrix plus valid bits, registered victim.
// Define LRU_LOCK_EN to add lock_mask exclusion and the alloc_fail indication.
module lru_way_tracker #(
    parameter int WAYS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    lru_way_tracker_if.slave   bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int NPAIR = WAYS * (WAYS - 1) / 2;

    // r_age bit for pair (i<j) is 1 when way i is older than way j
    logic [NPAIR-1:0] r_age;
    logic [NPAIR-1:0] w_age_nxt;
    logic [WAYS-1:0]  r_valid;
    logic [WAYS-1:0]  w_valid_nxt;
    logic             r_alloc_vld;
    logic [WAY_W-1:0] r_alloc_way;
    logic             r_all_valid;

    logic [WAYS-1:0]  w_older [WAYS];
    logic [WAYS-1:0]  w_cand;
    logic [WAYS-1:0]  w_inv_cand;
    logic [WAYS-1:0]  w_inv_sel;
    logic [WAYS-1:0]  w_is_oldest;
    logic [WAYS-1:0]  w_sel;
    logic [WAYS-1:0]  w_enc [WAY_W];
    logic [WAY_W-1:0] w_victim;
    logic             w_none;
    logic             w_alloc_ok;
    logic [WAYS-1:0]  w_ref_hot;
    logic [WAYS-1:0]  w_inv_hot;
    logic [WAYS-1:0]  w_alc_hot;

`ifdef LRU_LOCK_EN
    logic             r_alloc_fail;

    assign w_cand = ~bus.lock_mask;
    assign w_none = ~|w_cand;
`else
    assign w_cand = '1;
    assign w_none = 1'b0;
`endif

    assign w_inv_cand = w_cand & ~r_valid;
    assign w_sel      = (|w_inv_cand) ? w_inv_sel : w_is_oldest;
    assign w_alloc_ok = bus.alloc_req & ~w_none;
    assign w_alc_hot  = {WAYS{w_alloc_ok}} & w_sel;

    // Per-way decode: full older-than matrix row, victim candidates, request one-hots
    for (genvar gv = 0; gv < WAYS; gv++) begin : g_way
        localparam logic [WAYS-1:0] LOWER = WAYS'((64'd1 << gv) - 64'd1);

        assign w_older[gv][gv] = 1'b1;
        assign w_inv_sel[gv]   = w_inv_cand[gv] & ~|(w_inv_cand & LOWER);
        assign w_is_oldest[gv] = w_cand[gv] & (&(~w_cand | w_older[gv]));
        assign w_ref_hot[gv]   = bus.ref_vld & (bus.ref_way == WAY_W'(gv));
        assign w_inv_hot[gv]   = bus.inv_vld & (bus.inv_way == WAY_W'(gv));
        assign w_valid_nxt[gv] = w_alc_hot[gv] ? 1'b1 :
                                 w_inv_hot[gv] ? 1'b0 : r_valid[gv];
    end

    // Ref, then inv, then alloc: later stages override earlier ones on shared bits
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < WAYS; gj++) begin : g_pair
            localparam int P = gi * WAYS - gi * (gi + 1) / 2 + (gj - gi - 1);
            logic w_s_ref;
            logic w_s_inv;

            assign w_older[gi][gj] = r_age[P];
            assign w_older[gj][gi] = ~r_age[P];

            assign w_s_ref   = w_ref_hot[gi] ? 1'b0 :
                               w_ref_hot[gj] ? 1'b1 : r_age[P];
            assign w_s_inv   = w_inv_hot[gi] ? 1'b1 :
                               w_inv_hot[gj] ? 1'b0 : w_s_ref;
            assign w_age_nxt[P] = w_alc_hot[gi] ? 1'b0 :
                                  w_alc_hot[gj] ? 1'b1 : w_s_inv;
        end
    end

    // One-hot victim select to binary index
    for (genvar gb = 0; gb < WAY_W; gb++) begin : g_enc
        for (genvar gv = 0; gv < WAYS; gv++) begin : g_term
            if (((gv >> gb) & 1) == 1) begin : g_on
                assign w_enc[gb][gv] = w_sel[gv];
            end else begin : g_off
                assign w_enc[gb][gv] = 1'b0;
            end
        end
        assign w_victim[gb] = |w_enc[gb];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age       <= '1;
            r_valid     <= '0;
            r_alloc_vld <= 1'b0;
            r_alloc_way <= '0;
            r_all_valid <= 1'b0;
        end else begin
            r_age       <= w_age_nxt;
            r_valid     <= w_valid_nxt;
            r_alloc_vld <= bus.alloc_req;
            r_all_valid <= &w_valid_nxt;
            if (bus.alloc_req) begin
                r_alloc_way <= w_victim;
            end
        end
    end

`ifdef LRU_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alloc_fail <= 1'b0;
        end else if (bus.alloc_req) begin
            r_alloc_fail <= w_none;
        end
    end

    assign bus.alloc_fail = r_alloc_fail;
`else
    assign bus.alloc_fail = 1'b0;
`endif

    assign bus.alloc_vld = r_alloc_vld;
    assign bus.alloc_way = r_alloc_way;
    assign bus.all_valid = r_all_valid;

    // A consistent total order has exactly one oldest candidate
    a_oldest_unique: assert property (@(posedge clk) disable iff (!rst_n)
        w_none || $onehot(w_is_oldest));

endmodule

// File: tb/tb_lru_way_tracker.sv
// Directed bench for lru_way_tracker: WAYS=4 scenarios plus fill/LRU sweep at WAYS=2,8,16.
module tb_lru_way_tracker;
    logic clk = 1'b0;
    logic rst_n;
    logic sweep_go = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    lru_way_tracker_if #(.WAYS(4)) b4 ();
    lru_way_tracker #(.WAYS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    // Fill and LRU ordering at other sizes
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SW  = (g == 0) ? 2 : (g == 1) ? 8 : 16;
        localparam int SWW = $clog2(SW);
        logic done_l;

        lru_way_tracker_if #(.WAYS(SW)) sb ();
        lru_way_tracker #(.WAYS(SW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(sb.slave));

        initial begin
            done_l       = 1'b0;
            sb.ref_vld   = 1'b0;
            sb.ref_way   = '0;
            sb.inv_vld   = 1'b0;
            sb.inv_way   = '0;
            sb.alloc_req = 1'b0;
`ifdef LRU_LOCK_EN
            sb.lock_mask = '0;
`endif
            wait (sweep_go);
            sb.alloc_req = 1'b1;
            for (int k = 0; k < SW; k++) begin
                cyc();
                check_eq($sformatf("sw%0d_fill%0d", SW, k), 32'(sb.alloc_way), k);
            end
            sb.alloc_req = 1'b0;
            check_eq($sformatf("sw%0d_allvalid", SW), 32'(sb.all_valid), 1);
            sb.ref_vld = 1'b1;
            sb.ref_way = '0;
            cyc();
            sb.ref_vld   = 1'b0;
            sb.alloc_req = 1'b1;
            cyc();
            sb.alloc_req = 1'b0;
            check_eq($sformatf("sw%0d_lru1", SW), 32'(sb.alloc_way), 1);
            for (int k = SW - 1; k >= 0; k--) begin
                sb.ref_vld = 1'b1;
                sb.ref_way = SWW'(k);
                cyc();
            end
            sb.ref_vld   = 1'b0;
            sb.alloc_req = 1'b1;
            cyc();
            check_eq($sformatf("sw%0d_lru2", SW), 32'(sb.alloc_way), SW - 1);
            cyc();
            check_eq($sformatf("sw%0d_lru3", SW), 32'(sb.alloc_way), SW - 2);
            sb.alloc_req = 1'b0;
            done_l = 1'b1;
        end
    end

    task automatic w4_ref(input logic [1:0] w);
        b4.ref_vld = 1'b1;
        b4.ref_way = w;
        cyc();
        b4.ref_vld = 1'b0;
    endtask

    task automatic w4_inv(input logic [1:0] w);
        b4.inv_vld = 1'b1;
        b4.inv_way = w;
        cyc();
        b4.inv_vld = 1'b0;
    endtask

    task automatic w4_alloc(input string tag, input int exp_way, input int exp_av);
        b4.alloc_req = 1'b1;
        cyc();
        b4.alloc_req = 1'b0;
        check_eq({tag, "_vld"},  32'(b4.alloc_vld),  1);
        check_eq({tag, "_way"},  32'(b4.alloc_way),  exp_way);
        check_eq({tag, "_fail"}, 32'(b4.alloc_fail), 0);
        check_eq({tag, "_av"},   32'(b4.all_valid),  exp_av);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        b4.ref_vld   = 1'b0;
        b4.ref_way   = '0;
        b4.inv_vld   = 1'b0;
        b4.inv_way   = '0;
        b4.alloc_req = 1'b0;
`ifdef LRU_LOCK_EN
        b4.lock_mask = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_vld",  32'(b4.alloc_vld),  0);
        check_eq("rst_way",  32'(b4.alloc_way),  0);
        check_eq("rst_fail", 32'(b4.alloc_fail), 0);
        check_eq("rst_av",   32'(b4.all_valid),  0);

        sweep_go = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            if (g_sw[0].done_l && g_sw[1].done_l && g_sw[2].done_l) break;
            @(posedge clk);
        end
        #1;
        check_eq("sweep_done", {29'd0, g_sw[2].done_l, g_sw[1].done_l, g_sw[0].done_l}, 7);

        // Fill from reset: ways 0..3 in order, all_valid after the fourth
        b4.alloc_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_eq($sformatf("fill%0d_vld", k), 32'(b4.alloc_vld), 1);
            check_eq($sformatf("fill%0d_way", k), 32'(b4.alloc_way), k);
            check_eq($sformatf("fill%0d_av", k),  32'(b4.all_valid), (k == 3) ? 1 : 0);
        end
        b4.alloc_req = 1'b0;
        cyc();
        check_eq("idle_vld",  32'(b4.alloc_vld), 0);
        check_eq("idle_hold", 32'(b4.alloc_way), 3);

        w4_ref(2'd0);
        w4_alloc("lru1", 1, 1);
        w4_ref(2'd3);
        w4_ref(2'd1);
        w4_ref(2'd0);
        w4_ref(2'd2);
        w4_alloc("lru2", 3, 1);

        w4_inv(2'd2);
        check_eq("inv_av", 32'(b4.all_valid), 0);
        w4_alloc("inv_pref", 2, 1);

        // Order 1,0,3,2: way 1 is the victim of a ref+inv+alloc on way 1
        b4.ref_vld = 1'b1; b4.ref_way = 2'd1;
        b4.inv_vld = 1'b1; b4.inv_way = 2'd1;
        w4_alloc("simA", 1, 1);
        b4.ref_vld = 1'b0; b4.inv_vld = 1'b0;
        w4_alloc("simA_next", 0, 1);

        // Order 3,2,1,0: victim 3, way 1 ends invalid
        b4.ref_vld = 1'b1; b4.ref_way = 2'd1;
        b4.inv_vld = 1'b1; b4.inv_way = 2'd1;
        w4_alloc("simB", 3, 0);
        b4.ref_vld = 1'b0; b4.inv_vld = 1'b0;
        w4_alloc("simB_inv", 1, 1);
        w4_alloc("simB_next", 2, 1);

        w4_inv(2'd3);
        w4_inv(2'd0);
        w4_alloc("low_inv0", 0, 0);
        w4_alloc("low_inv1", 3, 1);

        b4.alloc_req = 1'b1;
        cyc();
        check_eq("burst0", 32'(b4.alloc_way), 1);
        cyc();
        check_eq("burst1", 32'(b4.alloc_way), 2);
        cyc();
        check_eq("burst2", 32'(b4.alloc_way), 0);
        b4.alloc_req = 1'b0;

`ifdef LRU_LOCK_EN
        // Order 3,1,2,0 with all ways valid
        b4.lock_mask = 4'b1000;
        w4_alloc("lock_old", 1, 1);
        b4.lock_mask = 4'b1111;
        b4.alloc_req = 1'b1;
        cyc();
        b4.alloc_req = 1'b0;
        check_eq("lockall_vld",  32'(b4.alloc_vld),  1);
        check_eq("lockall_fail", 32'(b4.alloc_fail), 1);
        check_eq("lockall_way",  32'(b4.alloc_way),  0);
        check_eq("lockall_av",   32'(b4.all_valid),  1);
        b4.lock_mask = 4'b0000;
        w4_alloc("lock_nochg", 3, 1);
        w4_inv(2'd2);
        b4.lock_mask = 4'b0100;
        w4_alloc("lock_inv", 0, 0);
        b4.lock_mask = 4'b0000;
        w4_alloc("unlock_inv", 2, 1);
`endif

        // Asynchronous reset in the middle of a burst
        b4.alloc_req = 1'b1;
        cyc();
        check_eq("prerst_vld", 32'(b4.alloc_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_vld",  32'(b4.alloc_vld),  0);
        check_eq("arst_way",  32'(b4.alloc_way),  0);
        check_eq("arst_fail", 32'(b4.alloc_fail), 0);
        check_eq("arst_av",   32'(b4.all_valid),  0);
        cyc();
        check_eq("rsthold_vld", 32'(b4.alloc_vld), 0);
        rst_n = 1'b1;
        cyc();
        check_eq("postrst0_vld", 32'(b4.alloc_vld), 1);
        check_eq("postrst0_way", 32'(b4.alloc_way), 0);
        cyc();
        check_eq("postrst1_way", 32'(b4.alloc_way), 1);
        b4.alloc_req = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
